// File: rtl/thor2022_uop_sequencer_if.sv
// Macro-instruction input stream and micro-op output stream of the Thor2022 uop sequencer.
// master = decode/execute environment, slave = sequencer.
interface thor2022_uop_sequencer_if #(
  parameter int unsigned MAXR = 4,
  parameter int unsigned IMMW = 24
);
  logic                mi_valid;
  logic                mi_ready;
  logic [1:0]          mi_kind;
  logic [3:0]          mi_cnt;
  logic [MAXR*5-1:0]   mi_regs;
  logic [19:0]         mi_amt;
  logic [1:0]          mi_lk;
  logic [3:0]          mi_len;

  logic                uop_valid;
  logic                uop_ready;
  logic [2:0]          uop_op;
  logic [4:0]          uop_rd;
  logic [4:0]          uop_rs;
  logic [IMMW-1:0]     uop_imm;
  logic [1:0]          uop_lk;
  logic                uop_last;
  logic [3:0]          uop_incr;

  modport master (
    output mi_valid, mi_kind, mi_cnt, mi_regs, mi_amt, mi_lk, mi_len, uop_ready,
    input  mi_ready, uop_valid, uop_op, uop_rd, uop_rs, uop_imm, uop_lk, uop_last, uop_incr
  );

  modport slave (
    input  mi_valid, mi_kind, mi_cnt, mi_regs, mi_amt, mi_lk, mi_len, uop_ready,
    output mi_ready, uop_valid, uop_op, uop_rd, uop_rs, uop_imm, uop_lk, uop_last, uop_incr
  );
endinterface

// File: rtl/thor2022_uop_sequencer.sv
// Expands POPM/PUSHM/ENTER/LEAVE macro instructions into one micro-op per cycle.
// Micro-op fields are decoded combinationally from the latched macro and step index.
module thor2022_uop_sequencer #(
  parameter int unsigned MAXR    = 4,
  parameter int unsigned SLOT    = 16,
  parameter int unsigned IMMW    = 24,
  parameter int unsigned SP_REG  = 31,
  parameter int unsigned FP_REG  = 30,
  parameter int unsigned TMP_REG = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  thor2022_uop_sequencer_if.slave   bus,
  output logic                      illegal_o
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [1:0] K_POPM  = 2'd0;
  localparam logic [1:0] K_PUSHM = 2'd1;
  localparam logic [1:0] K_ENTER = 2'd2;
  localparam logic [1:0] K_LEAVE = 2'd3;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_ADDI  = 3'd3;
  localparam logic [2:0] OP_MFLK  = 3'd4;
  localparam logic [2:0] OP_MTLK  = 3'd5;
  localparam logic [2:0] OP_RTS   = 3'd6;

  localparam logic [4:0]      SP  = 5'(SP_REG);
  localparam logic [4:0]      FP  = 5'(FP_REG);
  localparam logic [4:0]      TMP = 5'(TMP_REG);
  localparam logic [IMMW-1:0] SLOT_W = IMMW'(SLOT);

  logic [0:0]        state_q, state_d;
  logic [1:0]        kind_q, kind_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [MAXR*5-1:0] regs_q, regs_d;
  logic [19:0]       amt_q, amt_d;
  logic [1:0]        lk_q, lk_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        k_q, k_d;
  logic              illegal_q, illegal_d;

  logic              mi_ready;
  logic              accept;
  logic              bad_cnt;
  logic              uop_valid;
  logic [2:0]        op;
  logic [4:0]        rd, rs;
  logic [IMMW-1:0]   imm;
  logic [1:0]        lk;
  logic              last;
  logic [3:0]        sel_idx;
  logic [4:0]        reg_sel;
  logic [IMMW-1:0]   cnt_w, k_w, amt_w;

  assign mi_ready  = (state_q == S_IDLE) && !flush_i;
  assign accept    = bus.mi_valid && mi_ready;
  assign bad_cnt   = (bus.mi_cnt == 4'd0) || (bus.mi_cnt > 4'(MAXR));
  assign uop_valid = (state_q == S_RUN);
  assign cnt_w     = IMMW'(cnt_q);
  assign k_w       = IMMW'(k_q);
  assign amt_w     = IMMW'(amt_q);

  // PUSHM step 0 is the SP adjust, so its register list is offset by one step.
  always_comb begin
    sel_idx = (kind_q == K_PUSHM) ? k_q - 4'd1 : k_q;
    reg_sel = '0;
    for (int unsigned i = 0; i < MAXR; i++) begin
      if (4'(i) == sel_idx) reg_sel = regs_q[i*5 +: 5];
    end
  end

  always_comb begin
    op   = OP_NOP;
    rd   = '0;
    rs   = '0;
    imm  = '0;
    lk   = '0;
    last = 1'b0;
    if (uop_valid) begin
      unique case (kind_q)
        K_POPM: begin
          if (k_q < cnt_q) begin
            op = OP_LOAD; rd = reg_sel; rs = SP; imm = k_w * SLOT_W;
          end else begin
            op = OP_ADDI; rd = SP; rs = SP; imm = cnt_w * SLOT_W; last = 1'b1;
          end
        end
        K_PUSHM: begin
          if (k_q == 4'd0) begin
            op = OP_ADDI; rd = SP; rs = SP; imm = '0 - (cnt_w * SLOT_W);
          end else begin
            op = OP_STORE; rd = reg_sel; rs = SP; imm = (cnt_w - k_w) * SLOT_W;
          end
          last = (k_q == cnt_q);
        end
        K_ENTER: begin
          unique case (k_q)
            4'd0:    begin op = OP_ADDI;  rd = SP;  rs = SP; imm = '0 - (SLOT_W * IMMW'(4)); end
            4'd1:    begin op = OP_STORE; rd = FP;  rs = SP; end
            4'd2:    begin op = OP_MFLK;  rd = TMP; lk = lk_q; end
            4'd3:    begin op = OP_STORE; rd = TMP; rs = SP; imm = SLOT_W; end
            4'd4:    begin op = OP_STORE; rs = SP; imm = SLOT_W * IMMW'(2); end
            4'd5:    begin op = OP_STORE; rs = SP; imm = SLOT_W * IMMW'(3); end
            4'd6:    begin op = OP_ADDI;  rd = FP;  rs = SP; end
            default: begin op = OP_ADDI;  rd = SP;  rs = SP; imm = '0 - amt_w; last = 1'b1; end
          endcase
        end
        default: begin
          unique case (k_q)
            4'd0:    begin op = OP_ADDI; rd = SP;  rs = FP; end
            4'd1:    begin op = OP_LOAD; rd = FP;  rs = SP; end
            4'd2:    begin op = OP_LOAD; rd = TMP; rs = SP; imm = SLOT_W; end
            4'd3:    begin op = OP_MTLK; rs = TMP; lk = lk_q; end
            4'd4:    begin op = OP_ADDI; rd = SP;  rs = SP; imm = amt_w + (SLOT_W * IMMW'(4)); end
            default: begin op = OP_RTS;  lk = lk_q; last = 1'b1; end
          endcase
        end
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    cnt_d     = cnt_q;
    regs_d    = regs_q;
    amt_d     = amt_q;
    lk_d      = lk_q;
    len_d     = len_q;
    k_d       = k_q;
    illegal_d = 1'b0;
    if (flush_i) begin
      state_d = S_IDLE;
    end else if (accept) begin
      kind_d = bus.mi_kind;
      cnt_d  = bus.mi_cnt;
      regs_d = bus.mi_regs;
      amt_d  = bus.mi_amt;
      lk_d   = bus.mi_lk;
      len_d  = bus.mi_len;
      k_d    = '0;
      if ((bus.mi_kind == K_POPM || bus.mi_kind == K_PUSHM) && bad_cnt) illegal_d = 1'b1;
      else                                                              state_d   = S_RUN;
    end else if (uop_valid && bus.uop_ready) begin
      if (last) state_d = S_IDLE;
      else      k_d     = k_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      kind_q    <= '0;
      cnt_q     <= '0;
      regs_q    <= '0;
      amt_q     <= '0;
      lk_q      <= '0;
      len_q     <= '0;
      k_q       <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      cnt_q     <= cnt_d;
      regs_q    <= regs_d;
      amt_q     <= amt_d;
      lk_q      <= lk_d;
      len_q     <= len_d;
      k_q       <= k_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.mi_ready  = mi_ready;
  assign bus.uop_valid = uop_valid;
  assign bus.uop_op    = op;
  assign bus.uop_rd    = rd;
  assign bus.uop_rs    = rs;
  assign bus.uop_imm   = imm;
  assign bus.uop_lk    = lk;
  assign bus.uop_last  = last;
  assign bus.uop_incr  = last ? len_q : 4'd0;
  assign illegal_o     = illegal_q;
endmodule

// File: tb/tb_thor2022_uop_sequencer.sv
// Randomised and directed bench for thor2022_uop_sequencer; a queue-based model
// expands each accepted macro into its expected micro-op list.
module tb_thor2022_uop_sequencer;
  localparam int unsigned MAXR = 4;
  localparam int unsigned SLOT = 16;
  localparam int unsigned IMMW = 24;
  localparam int SP = 31, FP = 30, TMP = 3;

  typedef struct packed {
    logic [2:0]      op;
    logic [4:0]      rd;
    logic [4:0]      rs;
    logic [IMMW-1:0] imm;
    logic [1:0]      lk;
    logic            last;
    logic [3:0]      incr;
  } uop_t;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic flush_i = 1'b0;
  logic illegal_o;

  thor2022_uop_sequencer_if #(.MAXR(MAXR), .IMMW(IMMW)) bus ();

  thor2022_uop_sequencer #(
    .MAXR(MAXR), .SLOT(SLOT), .IMMW(IMMW), .SP_REG(31), .FP_REG(30), .TMP_REG(3)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .bus(bus), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  uop_t exp_q[$];
  uop_t logq[$];
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;
  bit   ill_exp = 1'b0;
  int   rdy_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic uop_t mk(input int op, input int rd, input int rs, input longint imm, input int lk);
    uop_t u;
    u.op = 3'(op); u.rd = 5'(rd); u.rs = 5'(rs); u.imm = IMMW'(imm); u.lk = 2'(lk);
    u.last = 1'b0; u.incr = '0;
    return u;
  endfunction

  task automatic expand(input logic [1:0] kind, input logic [3:0] cnt, input logic [MAXR*5-1:0] regs,
                        input logic [19:0] amt, input logic [1:0] lk, input logic [3:0] len);
    uop_t   seq[$];
    uop_t   u;
    int     n = int'(cnt);
    longint a = longint'(amt);
    int     l = int'(lk);
    case (kind)
      2'd0: begin
        for (int i = 0; i < n; i++) seq.push_back(mk(1, int'(regs[i*5 +: 5]), SP, i*SLOT, 0));
        seq.push_back(mk(3, SP, SP, n*SLOT, 0));
      end
      2'd1: begin
        seq.push_back(mk(3, SP, SP, -n*SLOT, 0));
        for (int i = 0; i < n; i++) seq.push_back(mk(2, int'(regs[i*5 +: 5]), SP, (n-1-i)*SLOT, 0));
      end
      2'd2: begin
        seq.push_back(mk(3, SP, SP, -4*SLOT, 0));
        seq.push_back(mk(2, FP, SP, 0, 0));
        seq.push_back(mk(4, TMP, 0, 0, l));
        seq.push_back(mk(2, TMP, SP, SLOT, 0));
        seq.push_back(mk(2, 0, SP, 2*SLOT, 0));
        seq.push_back(mk(2, 0, SP, 3*SLOT, 0));
        seq.push_back(mk(3, FP, SP, 0, 0));
        seq.push_back(mk(3, SP, SP, -a, 0));
      end
      default: begin
        seq.push_back(mk(3, SP, FP, 0, 0));
        seq.push_back(mk(1, FP, SP, 0, 0));
        seq.push_back(mk(1, TMP, SP, SLOT, 0));
        seq.push_back(mk(5, 0, TMP, 0, l));
        seq.push_back(mk(3, SP, SP, a + 4*SLOT, 0));
        seq.push_back(mk(6, 0, 0, 0, l));
      end
    endcase
    u = seq.pop_back();
    u.last = 1'b1;
    u.incr = len;
    seq.push_back(u);
    foreach (seq[i]) exp_q.push_back(seq[i]);
  endtask

  uop_t act;
  bit   ev;
  always @(negedge clk) begin
    act.op = bus.uop_op; act.rd = bus.uop_rd; act.rs = bus.uop_rs; act.imm = bus.uop_imm;
    act.lk = bus.uop_lk; act.last = bus.uop_last; act.incr = bus.uop_incr;
    ev = (exp_q.size() != 0);
    if (chk_en) begin
      chk("uop_valid", 64'(bus.uop_valid), 64'(ev));
      if (ev) chk("uop_fields", 64'(act), 64'(exp_q[0]));
      chk("mi_ready", 64'(bus.mi_ready), 64'(!ev && !flush_i));
      chk("illegal_o", 64'(illegal_o), 64'(ill_exp));
    end
    ill_exp = 1'b0;
    if (rst_i || flush_i) begin
      exp_q.delete();
    end else begin
      if (ev && bus.uop_ready) begin
        logq.push_back(act);
        void'(exp_q.pop_front());
      end else if (!ev && bus.mi_valid) begin
        if (bus.mi_kind < 2'd2 && (bus.mi_cnt == 4'd0 || bus.mi_cnt > 4'(MAXR))) ill_exp = 1'b1;
        else expand(bus.mi_kind, bus.mi_cnt, bus.mi_regs, bus.mi_amt, bus.mi_lk, bus.mi_len);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.uop_ready = 1'b1;
      1:       bus.uop_ready = ~bus.uop_ready;
      default: bus.uop_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic send(input logic [1:0] kind, input logic [3:0] cnt, input logic [MAXR*5-1:0] regs,
                      input logic [19:0] amt, input logic [1:0] lk, input logic [3:0] len,
                      output int waits);
    bit ok = 1'b0;
    bus.mi_kind = kind; bus.mi_cnt = cnt; bus.mi_regs = regs;
    bus.mi_amt = amt; bus.mi_lk = lk; bus.mi_len = len;
    bus.mi_valid = 1'b1;
    waits = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (bus.mi_ready) begin ok = 1'b1; break; end
      waits++;
    end
    if (!ok) chk("accept_timeout", 64'(ok), 64'd1);
    @(posedge clk); #1;
    bus.mi_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin done = 1'b1; break; end
    end
    if (!done) chk("idle_timeout", 64'(done), 64'd1);
    @(posedge clk); #1;
  endtask

  int w;
  initial begin
    bus.mi_valid = 1'b0; bus.mi_kind = '0; bus.mi_cnt = '0; bus.mi_regs = '0;
    bus.mi_amt = '0; bus.mi_lk = '0; bus.mi_len = '0; bus.uop_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_uop_valid", 64'(bus.uop_valid), 64'd0);
    chk("rst_mi_ready", 64'(bus.mi_ready), 64'd1);
    chk("rst_illegal", 64'(illegal_o), 64'd0);
    chk("rst_fields", 64'({bus.uop_op, bus.uop_rd, bus.uop_rs, bus.uop_imm, bus.uop_lk, bus.uop_last, bus.uop_incr}), 64'd0);
    @(posedge clk); #1 rst_i = 1'b0;

    // POPM n=2 r={5,6}
    logq.delete();
    send(2'd0, 4'd2, 20'({5'd6, 5'd5}), 20'd0, 2'd0, 4'd3, w);
    wait_idle();
    chk("popm_count", 64'(logq.size()), 64'd3);
    chk("popm_u0", 64'({logq[0].op, logq[0].rd, logq[0].rs, logq[0].imm}), 64'({3'd1, 5'd5, 5'd31, 24'd0}));
    chk("popm_u1", 64'({logq[1].op, logq[1].rd, logq[1].imm}), 64'({3'd1, 5'd6, 24'd16}));
    chk("popm_u2", 64'({logq[2].op, logq[2].rd, logq[2].imm, logq[2].last, logq[2].incr}),
        64'({3'd3, 5'd31, 24'd32, 1'b1, 4'd3}));

    // PUSHM n=4 r={1,2,3,4}
    logq.delete();
    send(2'd1, 4'd4, 20'({5'd4, 5'd3, 5'd2, 5'd1}), 20'd0, 2'd0, 4'd2, w);
    wait_idle();
    chk("pushm_count", 64'(logq.size()), 64'd5);
    chk("pushm_u0", 64'({logq[0].op, logq[0].imm}), 64'({3'd3, 24'hFFFFC0}));
    chk("pushm_u1", 64'({logq[1].op, logq[1].rd, logq[1].imm}), 64'({3'd2, 5'd1, 24'd48}));
    chk("pushm_u4", 64'({logq[4].rd, logq[4].imm, logq[4].last}), 64'({5'd4, 24'd0, 1'b1}));

    // ENTER amt=0x100 under toggling back-pressure
    logq.delete();
    rdy_mode = 1;
    send(2'd2, 4'd0, 20'd0, 20'h100, 2'd2, 4'd4, w);
    wait_idle();
    rdy_mode = 0;
    chk("enter_count", 64'(logq.size()), 64'd8);
    chk("enter_u7", 64'({logq[7].op, logq[7].imm, logq[7].last}), 64'({3'd3, 24'hFFFF00, 1'b1}));

    // LEAVE amt=0x40 lk=1
    logq.delete();
    send(2'd3, 4'd0, 20'd0, 20'h40, 2'd1, 4'd2, w);
    wait_idle();
    chk("leave_count", 64'(logq.size()), 64'd6);
    chk("leave_u4", 64'({logq[4].op, logq[4].imm}), 64'({3'd3, 24'h80}));
    chk("leave_u5", 64'({logq[5].op, logq[5].lk, logq[5].last}), 64'({3'd6, 2'd1, 1'b1}));

    // Illegal counts 0 and MAXR+1
    for (int c = 0; c < 2; c++) begin
      send(2'd0, (c == 0) ? 4'd0 : 4'(MAXR + 1), 20'd0, 20'd0, 2'd0, 4'd2, w);
      @(negedge clk);
      chk("illegal_pulse", 64'(illegal_o), 64'd1);
      chk("illegal_no_uop", 64'(bus.uop_valid), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("illegal_one_cycle", 64'(illegal_o), 64'd0);
      chk("illegal_ready", 64'(bus.mi_ready), 64'd1);
      @(posedge clk); #1;
    end

    // Flush on the 3rd ENTER uop, then a POPM is taken immediately
    logq.delete();
    send(2'd2, 4'd0, 20'd0, 20'h20, 2'd0, 4'd4, w);
    @(posedge clk); #1;
    @(posedge clk); #1 flush_i = 1'b1;
    @(posedge clk); #1 flush_i = 1'b0;
    chk("flush_issued", 64'(logq.size()), 64'd2);
    logq.delete();
    send(2'd0, 4'd1, 20'd7, 20'd0, 2'd0, 4'd2, w);
    chk("flush_accept_wait", 64'(w), 64'd0);
    wait_idle();
    chk("flush_popm_count", 64'(logq.size()), 64'd2);

    // Randomised macros, back-pressure and flushes
    rdy_mode = 2;
    for (int it = 0; it < 80; it++) begin
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, MAXR + 1)), 20'($urandom),
           20'($urandom), 2'($urandom), 4'($urandom), w);
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk); #1 flush_i = 1'b0;
      end
    end
    wait_idle();

    // Reset in the middle of a sequence
    rdy_mode = 0;
    send(2'd1, 4'd3, 20'($urandom), 20'd0, 2'd0, 4'd1, w);
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk("midrst_uop_valid", 64'(bus.uop_valid), 64'd0);
    chk("midrst_mi_ready", 64'(bus.mi_ready), 64'd1);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
